button_press_tracker: RTL and testbench
=======================================

# button_press_tracker

Parametrised multi-channel push-button front end for the board-level user-interface path. It synchronises and debounces NUM_BUTTONS raw button inputs using a shared sample prescaler and a per-channel press/release state machine. It emits one-cycle press/release pulses and keeps a per-channel press counter with sticky overflow. One selected counter drives the LED bank, replacing ad-hoc single-button press counting in the top level.

## Interface
- NUM_BUTTONS, 4, number of independent button channels (1..16)
- SAMPLE_TICKS, 1_000_000, clk cycles between debounce samples (10 ms at 100 MHz); minimum 2
- STABLE_SAMPLES, 2, consecutive samples at the new level required to accept a change; minimum 1
- COUNT_W, 8, width of each press counter and of LEDs
- ACTIVE_LOW, 1, 1 = raw input 0 means pressed (board buttons); 0 = active-high
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- buttons  in  NUM_BUTTONS  raw asynchronous button levels
- clear  in  1  synchronous clear of all press counters and overflow flags
- sel  in  max(1,$clog2(NUM_BUTTONS))  channel whose count drives LEDs; out-of-range values give LEDs = 0
- debounced  out  NUM_BUTTONS  filtered level per channel, 1 = pressed (polarity-normalised)
- press_pulse  out  NUM_BUTTONS  one-cycle pulse on accepted press
- release_pulse  out  NUM_BUTTONS  one-cycle pulse on accepted release
- overflow  out  NUM_BUTTONS  sticky, set when a counter wraps
- LEDs  out  COUNT_W  registered press count of channel sel

## Operation
- Input path: 2-flop synchroniser per channel, then polarity normalisation (pressed = 1).
- Prescaler: a single counter runs 0..SAMPLE_TICKS-1 and wraps. `tick` is asserted for one cycle when the counter equals SAMPLE_TICKS-1. All channels sample only on `tick`.
- Per-channel FSM, evaluated on `tick` only:
  - RELEASED: sample = 1 → PRESS_PEND, stab = 1. If STABLE_SAMPLES = 1, go directly to PRESSED.
  - PRESS_PEND: sample = 1 → stab++. When stab reaches STABLE_SAMPLES → PRESSED and press_pulse. Sample = 0 → RELEASED, stab = 0 (glitch rejected).
  - PRESSED: sample = 0 → REL_PEND, with the same STABLE_SAMPLES = 1 shortcut.
  - REL_PEND: sample = 0 → count up; on reaching STABLE_SAMPLES → RELEASED and release_pulse. Sample = 1 → PRESSED.
- debounced = 1 in PRESSED and REL_PEND.
- stab is $clog2(STABLE_SAMPLES+1) bits wide and never exceeds STABLE_SAMPLES.
- Counter: increments on press_pulse and wraps modulo 2^COUNT_W. Wrapping from all-ones to 0 sets overflow; overflow stays set until clear or rst.
- clear: zeroes all counters and overflow flags in the same cycle.
  - clear and press_pulse in the same cycle: clear wins, and the press is not counted.
  - The FSM and pulses are unaffected by clear.
- Channels are fully independent. Simultaneous presses on several channels are each counted in the same cycle.

## Timing
- Reset values:
  - All outputs 0.
  - FSMs in RELEASED, prescaler 0, stab 0.
  - Synchroniser flops load the released level: 1 if ACTIVE_LOW, else 0. No spurious press follows reset.
- rst asserted mid-operation aborts any pending state next cycle. No pulse is emitted for the aborted transition.
- Press latency: from a clean raw edge to press_pulse is 2 + (STABLE_SAMPLES-1)·SAMPLE_TICKS + 1 cycles minimum and 2 + STABLE_SAMPLES·SAMPLE_TICKS + 1 cycles maximum. Release latency is identical.
- press_pulse/release_pulse are registered, high for exactly one cycle, at most one per `tick` per channel.
- Counter updates in the cycle after press_pulse is high. LEDs follow one further cycle later, and one cycle after a sel change.
- Pulses shorter than (STABLE_SAMPLES-1)·SAMPLE_TICKS cycles never produce a pulse.

## Structure
- Shared package button_pkg:
  - btn_state_t enum {BTN_RELEASED, BTN_PRESS_PEND, BTN_PRESSED, BTN_REL_PEND}.
  - Default constants for sample period at 100 MHz and default stable count.
- Sub-module button_debounce_channel, one per channel via generate:
  - Contains the synchroniser, FSM, stab counter, pulses, press counter and overflow.
  - Inputs: tick, clear, polarity parameter.
- Top level holds the prescaler, the channel array and the registered sel mux for LEDs.

## Test plan
All scenarios use NUM_BUTTONS=4, SAMPLE_TICKS=4, STABLE_SAMPLES=2, COUNT_W=8, ACTIVE_LOW=1.
- Reset with buttons = 4'b1111 → all outputs 0 for 50 cycles. Hold rst high with buttons = 4'b0000 → still no pulses.
- Clean press: buttons[3] driven low and held → press_pulse[3] exactly once, 7–11 cycles later. Then debounced[3] = 1; LEDs = 1 with sel = 3.
- Glitch: buttons[0] low for 3 cycles then high → no press_pulse[0], debounced[0] stays 0, count stays 0.
- Wrap: 256 clean presses on channel 1 → LEDs (sel = 1) returns to 0 and overflow[1] = 1. Then clear → overflow[1] = 0.
- Simultaneous: all four buttons pressed on the same cycle → four press_pulses in the same cycle. clear asserted on that cycle → all counts remain 0.
- Reset mid-debounce: rst asserted while channel 2 is in PRESS_PEND → no press_pulse[2] is emitted, and the FSM restarts from RELEASED after reset.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and default constants for the push-button front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package button_pkg;

    typedef enum logic [1:0] {
        BTN_RELEASED,
        BTN_PRESS_PEND,
        BTN_PRESSED,
        BTN_REL_PEND
    } btn_state_t;

    // 10 ms debounce sample period at a 100 MHz clock
    localparam int BTN_SAMPLE_TICKS_100MHZ = 1_000_000;
    localparam int BTN_STABLE_SAMPLES      = 2;

endpackage

// File: rtl/button_debounce_channel.sv
// One button channel: synchroniser, tick-sampled press/release FSM, press counter with sticky overflow.
// Latency: raw edge to pulse 3 + (STABLE_SAMPLES-1..STABLE_SAMPLES) ticks; count one cycle after pulse.
// Backpressure: none; pulses are single-cycle and never stall.
module button_debounce_channel
    import button_pkg::*;
#(
    parameter int STABLE_SAMPLES = BTN_STABLE_SAMPLES,
    parameter int COUNT_W        = 8,
    parameter int ACTIVE_LOW     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               raw,
    input  logic               tick,
    input  logic               clear,
    output logic               debounced,
    output logic               press_pulse,
    output logic               release_pulse,
    output logic               overflow,
    output logic [COUNT_W-1:0] count
);

    localparam int   STAB_W  = $clog2(STABLE_SAMPLES + 1);
    localparam logic REL_LVL = (ACTIVE_LOW != 0);

    logic              sync1, sync2, sample;
    btn_state_t        state, state_nxt;
    logic [STAB_W-1:0] stab, stab_nxt, stab_inc;
    logic              stab_done;
    logic              press_nxt, release_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= REL_LVL;
            sync2 <= REL_LVL;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    assign sample    = sync2 ^ REL_LVL;
    assign stab_inc  = stab + STAB_W'(1);
    // stab is 0 in the settled states, so this also covers the STABLE_SAMPLES = 1 shortcut
    assign stab_done = (stab_inc == STAB_W'(STABLE_SAMPLES));

    always_comb begin
        state_nxt   = state;
        stab_nxt    = stab;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        if (tick) begin
            case (state)
                BTN_RELEASED, BTN_PRESS_PEND: begin
                    if (!sample) begin
                        state_nxt = BTN_RELEASED;
                        stab_nxt  = '0;
                    end else if (stab_done) begin
                        state_nxt = BTN_PRESSED;
                        stab_nxt  = '0;
                        press_nxt = 1'b1;
                    end else begin
                        state_nxt = BTN_PRESS_PEND;
                        stab_nxt  = stab_inc;
                    end
                end
                BTN_PRESSED, BTN_REL_PEND: begin
                    if (sample) begin
                        state_nxt = BTN_PRESSED;
                        stab_nxt  = '0;
                    end else if (stab_done) begin
                        state_nxt   = BTN_RELEASED;
                        stab_nxt    = '0;
                        release_nxt = 1'b1;
                    end else begin
                        state_nxt = BTN_REL_PEND;
                        stab_nxt  = stab_inc;
                    end
                end
                default: begin
                    state_nxt = BTN_RELEASED;
                    stab_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= BTN_RELEASED;
            stab          <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            stab          <= stab_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
        end
    end

    assign debounced = (state == BTN_PRESSED) || (state == BTN_REL_PEND);

    // clear outranks a coincident press, which is then dropped
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (press_pulse) begin
            count <= count + COUNT_W'(1);
            if (&count)
                overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/button_press_tracker.sv
// Multi-channel debounced button tracker with shared sample prescaler and registered LED count mux.
// Latency: LEDs follow a counter or sel change by one cycle.
// Backpressure: none; all outputs are free-running.
module button_press_tracker
    import button_pkg::*;
#(
    parameter int NUM_BUTTONS    = 4,
    parameter int SAMPLE_TICKS   = BTN_SAMPLE_TICKS_100MHZ,
    parameter int STABLE_SAMPLES = BTN_STABLE_SAMPLES,
    parameter int COUNT_W        = 8,
    parameter int ACTIVE_LOW     = 1,
    localparam int SEL_W         = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_BUTTONS-1:0] buttons,
    input  logic                   clear,
    input  logic [SEL_W-1:0]       sel,
    output logic [NUM_BUTTONS-1:0] debounced,
    output logic [NUM_BUTTONS-1:0] press_pulse,
    output logic [NUM_BUTTONS-1:0] release_pulse,
    output logic [NUM_BUTTONS-1:0] overflow,
    output logic [COUNT_W-1:0]     LEDs
);

    localparam int PRESC_W = $clog2(SAMPLE_TICKS);

    logic [PRESC_W-1:0] presc;
    logic               tick;
    logic [COUNT_W-1:0] counts [NUM_BUTTONS];
    logic [COUNT_W-1:0] led_nxt;

    assign tick = (presc == PRESC_W'(SAMPLE_TICKS - 1));

    always_ff @(posedge clk) begin
        if (rst || tick)
            presc <= '0;
        else
            presc <= presc + PRESC_W'(1);
    end

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan
        button_debounce_channel #(
            .STABLE_SAMPLES (STABLE_SAMPLES),
            .COUNT_W        (COUNT_W),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_chan (
            .clk           (clk),
            .rst           (rst),
            .raw           (buttons[g]),
            .tick          (tick),
            .clear         (clear),
            .debounced     (debounced[g]),
            .press_pulse   (press_pulse[g]),
            .release_pulse (release_pulse[g]),
            .overflow      (overflow[g]),
            .count         (counts[g])
        );
    end

    // sel values with no matching channel fall through to zero
    always_comb begin
        led_nxt = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (int'(sel) == i)
                led_nxt = counts[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            LEDs <= '0;
        else
            LEDs <= led_nxt;
    end

endmodule

// File: tb/tb_button_press_tracker.sv
// Bench for button_press_tracker: directed scenarios plus random button traffic against a behavioural model.
module tb_button_press_tracker;

    localparam int NB = 4;
    localparam int ST = 4;
    localparam int SS = 2;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] buttons = '1;
    logic          clear = 1'b0;
    logic [1:0]    sel = '0;
    logic [NB-1:0] debounced, press_pulse, release_pulse, overflow;
    logic [CW-1:0] LEDs;

    int tests = 0;
    int fails = 0;

    button_press_tracker #(
        .NUM_BUTTONS(NB), .SAMPLE_TICKS(ST), .STABLE_SAMPLES(SS), .COUNT_W(CW), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .buttons(buttons), .clear(clear), .sel(sel),
        .debounced(debounced), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .overflow(overflow), .LEDs(LEDs)
    );

    always #5 clk = ~clk;

    // Reference model: the accepted level of a channel flips once SS consecutive
    // tick samples (raw delayed two clocks, pressed = low) disagree with it.
    logic [NB-1:0] m_raw_d1, m_raw_d2, m_level, m_pp, m_rp, m_ovf;
    logic [CW-1:0] m_cnt [NB];
    logic [CW-1:0] m_leds;
    int            m_disagree [NB];
    int            m_edges;

    wire  [4*NB+CW-1:0] obs = {debounced, press_pulse, release_pulse, overflow, LEDs};
    logic [4*NB+CW-1:0] exp_v;
    always_comb exp_v = {m_level, m_pp, m_rp, m_ovf, m_leds};

    task automatic step();
        logic [NB-1:0] smp;
        @(posedge clk);
        if (rst) begin
            m_raw_d1 = '1; m_raw_d2 = '1;
            m_level = '0; m_pp = '0; m_rp = '0; m_ovf = '0; m_leds = '0; m_edges = 0;
            for (int i = 0; i < NB; i++) begin
                m_cnt[i] = '0;
                m_disagree[i] = 0;
            end
        end else begin
            m_leds = m_cnt[sel];
            for (int i = 0; i < NB; i++) begin
                if (clear) begin
                    m_cnt[i] = '0;
                    m_ovf[i] = 1'b0;
                end else if (m_pp[i]) begin
                    if (m_cnt[i] == 8'd255) m_ovf[i] = 1'b1;
                    m_cnt[i] = m_cnt[i] + 8'd1;
                end
            end
            smp = ~m_raw_d2;
            m_pp = '0; m_rp = '0;
            if (m_edges % ST == ST - 1) begin
                for (int i = 0; i < NB; i++) begin
                    if (smp[i] != m_level[i]) begin
                        m_disagree[i]++;
                        if (m_disagree[i] >= SS) begin
                            m_level[i] = smp[i];
                            if (smp[i]) m_pp[i] = 1'b1; else m_rp[i] = 1'b1;
                            m_disagree[i] = 0;
                        end
                    end else begin
                        m_disagree[i] = 0;
                    end
                end
            end
            m_edges++;
            m_raw_d2 = m_raw_d1;
            m_raw_d1 = buttons;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; buttons = '1;
        for (int k = 0; k < 50; k++) begin
            step();
            tests++;
            if (obs !== '0) begin
                fails++;
                $display("FAIL reset_outputs cyc %0d: got %h want 0", k, obs);
            end
        end
        buttons = '0;
        for (int k = 0; k < 12; k++) begin
            step();
            tests++;
            if ((press_pulse | release_pulse) !== '0) begin
                fails++;
                $display("FAIL reset_held_pulse cyc %0d: got %b want 0", k, press_pulse);
            end
        end
        buttons = '1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL post_reset cyc %0d: got %h want %h", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_clean_press();
        int npulse = 0;
        int lat = -1;
        sel = 2'd3;
        buttons[3] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL clean_model cyc %0d: got %h want %h", k, obs, exp_v);
            end
            if (press_pulse[3]) begin
                npulse++;
                if (lat < 0) lat = k;
            end
        end
        tests++;
        if (npulse != 1 || lat < 7 || lat > 11) begin
            fails++;
            $display("FAIL clean_latency: got %0d pulses at %0d want 1 pulse in 7..11", npulse, lat);
        end
        tests++;
        if (debounced[3] !== 1'b1 || LEDs !== 8'd1) begin
            fails++;
            $display("FAIL clean_count: got deb %b leds %0d want 1 1", debounced[3], LEDs);
        end
        buttons[3] = 1'b1;
        npulse = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL clean_rel_model cyc %0d: got %h want %h", k, obs, exp_v);
            end
            if (release_pulse[3]) npulse++;
        end
        tests++;
        if (npulse != 1 || debounced[3] !== 1'b0) begin
            fails++;
            $display("FAIL clean_release: got %0d pulses deb %b want 1 0", npulse, debounced[3]);
        end
    endtask

    task automatic test_glitch();
        int npulse = 0;
        sel = 2'd0;
        buttons[0] = 1'b0;
        for (int k = 0; k < 23; k++) begin
            if (k == 3) buttons[0] = 1'b1;
            step();
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL glitch_model cyc %0d: got %h want %h", k, obs, exp_v);
            end
            if (press_pulse[0] || debounced[0]) npulse++;
        end
        tests++;
        if (npulse != 0 || LEDs !== 8'd0) begin
            fails++;
            $display("FAIL glitch_reject: got %0d press cycles leds %0d want 0 0", npulse, LEDs);
        end
    endtask

    task automatic test_wrap();
        sel = 2'd1;
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int p = 0; p < 256; p++) begin
            for (int k = 0; k < 24; k++) begin
                buttons[1] = (k >= 12);
                step();
                tests++;
                if (obs !== exp_v) begin
                    fails++;
                    $display("FAIL wrap_model press %0d cyc %0d: got %h want %h", p, k, obs, exp_v);
                end
            end
            if (p == 254) begin
                tests++;
                if (LEDs !== 8'd255 || overflow[1] !== 1'b0) begin
                    fails++;
                    $display("FAIL wrap_255: got leds %0d ovf %b want 255 0", LEDs, overflow[1]);
                end
            end
        end
        tests++;
        if (LEDs !== 8'd0 || overflow[1] !== 1'b1) begin
            fails++;
            $display("FAIL wrap_256: got leds %0d ovf %b want 0 1", LEDs, overflow[1]);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
        tests++;
        if (overflow[1] !== 1'b0 || obs !== exp_v) begin
            fails++;
            $display("FAIL wrap_clear: got ovf %b obs %h want 0 %h", overflow[1], obs, exp_v);
        end
    endtask

    task automatic test_simultaneous();
        bit seen = 0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        buttons = '0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL simul_model cyc %0d: got %h want %h", k, obs, exp_v);
            end
            if (press_pulse != '0) seen = 1;
        end
        tests++;
        if (press_pulse !== 4'b1111) begin
            fails++;
            $display("FAIL simul_pulses: got %b want 1111", press_pulse);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int s = 0; s < NB; s++) begin
            sel = 2'(s);
            step();
            step();
            tests++;
            if (LEDs !== 8'd0 || obs !== exp_v) begin
                fails++;
                $display("FAIL simul_clear ch %0d: got leds %0d want 0", s, LEDs);
            end
        end
        buttons = '1;
        for (int k = 0; k < 20; k++) step();
    endtask

    task automatic test_reset_mid();
        int npulse = 0;
        int lat = -1;
        buttons[2] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (press_pulse[2]) npulse++;
        end
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            if (press_pulse[2]) npulse++;
        end
        rst = 1'b0;
        tests++;
        if (npulse != 0) begin
            fails++;
            $display("FAIL rstmid_abort: got %0d pulses want 0", npulse);
        end
        for (int k = 1; k <= 20; k++) begin
            step();
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL rstmid_model cyc %0d: got %h want %h", k, obs, exp_v);
            end
            if (press_pulse[2]) begin
                npulse++;
                if (lat < 0) lat = k;
            end
        end
        tests++;
        if (npulse != 1 || lat != 8) begin
            fails++;
            $display("FAIL rstmid_restart: got %0d pulses at %0d want 1 at 8", npulse, lat);
        end
        buttons = '1;
        for (int k = 0; k < 20; k++) step();
    endtask

    task automatic test_random();
        int hold [NB];
        for (int i = 0; i < NB; i++) hold[i] = 0;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < NB; i++) begin
                if (hold[i] == 0) begin
                    buttons[i] = ~buttons[i];
                    hold[i] = $urandom_range(1, 20);
                end else begin
                    hold[i]--;
                end
            end
            clear = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 29) == 0) sel = 2'($urandom_range(0, 3));
            step();
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL random_model cyc %0d: got %h want %h", k, obs, exp_v);
            end
        end
        clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_wrap();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
